// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 parallel bus as seen from the display side: enable strobe, register select,
// direction and data. The controller drives it, the responder only listens.
interface lcd_hd44780_responder_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (output LCD_E, output LCD_RS, output LCD_RW, output LCD_DATA);
    modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  LCD_DATA);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// HD44780-style 16x2 text-LCD responder: decodes bus transactions on the falling edge of E,
// keeps the 80-byte DDRAM, address counter, display flags, busy flag and overrun counter.
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 96,
    parameter int OVR_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lcd_hd44780_responder_if.slave lcd,
    input  logic [6:0]             dbg_addr,
    output logic [7:0]             dbg_data,
    output logic [7:0]             bf_ac,
    output logic                   busy,
    output logic                   disp_on,
    output logic                   cursor_on,
    output logic                   blink_on,
    output logic                   id_inc,
    output logic                   entry_shift,
    output logic                   two_line,
    output logic [5:0]             disp_shift,
    output logic                   wr_strobe,
    output logic                   cmd_err,
    output logic [OVR_W-1:0]       ovr_cnt
);
    typedef enum logic [1:0] {
        S_INIT_FILL  = 2'd0,
        S_IDLE       = 2'd1,
        S_EXEC       = 2'd2,
        S_CLEAR_FILL = 2'd3
    } state_t;

    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] FILL_LAST  = 16'd79;

    function automatic logic [6:0] ddram_index(input logic [6:0] ac);
        return (ac[6] ? 7'd40 : 7'd0) + {1'b0, ac[5:0]};
    endfunction

    // Line-aware AC stepping; one-line mode treats 0x00-0x4F as a single ring.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up, input logic two);
        logic [6:0] r;
        if (two) begin
            if (up) begin
                if (ac == 7'h27)      r = 7'h40;
                else if (ac == 7'h67) r = 7'h00;
                else                  r = ac + 7'd1;
            end else begin
                if (ac == 7'h00)      r = 7'h67;
                else if (ac == 7'h40) r = 7'h27;
                else                  r = ac - 7'd1;
            end
        end else begin
            if (up) r = (ac >= 7'h4F) ? 7'h00 : ac + 7'd1;
            else    r = (ac == 7'h00) ? 7'h4F : ac - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        logic [5:0] r;
        if (up) r = (s >= 6'd39) ? 6'd0 : s + 6'd1;
        else    r = (s == 6'd0) ? 6'd39 : s - 6'd1;
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [15:0]      cnt_r, cnt_s;
    logic             e_d_r;
    logic [6:0]       ac_r, ac_s;
    logic             disp_on_r, disp_on_s, cursor_on_r, cursor_on_s, blink_on_r, blink_on_s;
    logic             id_inc_r, id_inc_s, entry_shift_r, entry_shift_s, two_line_r, two_line_s;
    logic [5:0]       shift_r, shift_s;
    logic             wr_strobe_r, wr_strobe_s, cmd_err_r, cmd_err_s, busy_r;
    logic [OVR_W-1:0] ovr_r, ovr_s;
    logic [7:0]       dbg_data_r;
    logic [7:0]       ram_r [0:79];
    logic             ram_we_s;
    logic [6:0]       ram_idx_s, dbg_idx_s;
    logic [7:0]       ram_wd_s;
    logic             txn_s, status_rd_s, acc_s, drop_s, is_clear_s;

    assign txn_s       = e_d_r & ~lcd.LCD_E;
    assign status_rd_s = txn_s & ~lcd.LCD_RS & lcd.LCD_RW;
    assign acc_s       = txn_s & ~status_rd_s & (state_r == S_IDLE);
    assign drop_s      = txn_s & ~status_rd_s & (state_r != S_IDLE);
    assign is_clear_s  = ~lcd.LCD_RS & ~lcd.LCD_RW & (lcd.LCD_DATA == 8'h01);
    assign dbg_idx_s   = ddram_index(dbg_addr);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_INIT_FILL;
        else      state_r <= state_s;
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_INIT_FILL:  if (cnt_r == FILL_LAST) state_s = S_IDLE; else state_s = S_INIT_FILL;
            S_IDLE: begin
                if (acc_s) state_s = is_clear_s ? S_CLEAR_FILL : S_EXEC;
                else       state_s = S_IDLE;
            end
            S_EXEC:       if (cnt_r == 16'd0) state_s = S_IDLE; else state_s = S_EXEC;
            S_CLEAR_FILL: if (cnt_r == CLEAR_LAST) state_s = S_IDLE; else state_s = S_CLEAR_FILL;
            default:      state_s = S_INIT_FILL;
        endcase
    end

    // Output / datapath next values: instruction decode, DDRAM write port, counters
    always_comb begin
        cnt_s = cnt_r;  ac_s = ac_r;  shift_s = shift_r;
        disp_on_s = disp_on_r;  cursor_on_s = cursor_on_r;  blink_on_s = blink_on_r;
        id_inc_s = id_inc_r;  entry_shift_s = entry_shift_r;  two_line_s = two_line_r;
        wr_strobe_s = 1'b0;  cmd_err_s = 1'b0;
        ram_we_s = 1'b0;  ram_idx_s = 7'd0;  ram_wd_s = 8'h00;
        case (state_r)
            S_INIT_FILL, S_CLEAR_FILL: begin
                ram_we_s  = (cnt_r < 16'd80);
                ram_idx_s = cnt_r[6:0];
                ram_wd_s  = 8'h20;
                cnt_s     = cnt_r + 16'd1;
            end
            S_EXEC: cnt_s = cnt_r - 16'd1;
            S_IDLE: begin
                cnt_s = BUSY_LAST;
                if (!acc_s) begin
                    cnt_s = BUSY_LAST;
                end else if (lcd.LCD_RS) begin
                    if (lcd.LCD_RW) begin
                        cmd_err_s = 1'b1;
                    end else begin
                        ram_we_s    = 1'b1;
                        ram_idx_s   = ddram_index(ac_r);
                        ram_wd_s    = lcd.LCD_DATA;
                        wr_strobe_s = 1'b1;
                        ac_s        = ac_step(ac_r, id_inc_r, two_line_r);
                        if (entry_shift_r) shift_s = shift_step(shift_r, id_inc_r);
                        else               shift_s = shift_r;
                    end
                end else begin
                    casez (lcd.LCD_DATA)
                        8'b1???????: begin
                            if (lcd.LCD_DATA[5:0] <= 6'd39) ac_s = lcd.LCD_DATA[6:0];
                            else                            cmd_err_s = 1'b1;
                        end
                        8'b01??????: cmd_err_s = 1'b1;
                        8'b001?????: two_line_s = lcd.LCD_DATA[3];
                        8'b0001????: begin
                            if (lcd.LCD_DATA[3]) shift_s = shift_step(shift_r, lcd.LCD_DATA[2]);
                            else                 ac_s = ac_step(ac_r, lcd.LCD_DATA[2], two_line_r);
                        end
                        8'b00001???: {disp_on_s, cursor_on_s, blink_on_s} = lcd.LCD_DATA[2:0];
                        8'b000001??: {id_inc_s, entry_shift_s} = lcd.LCD_DATA[1:0];
                        8'b0000001?: begin ac_s = 7'd0; shift_s = 6'd0; end
                        8'b00000001: begin ac_s = 7'd0; shift_s = 6'd0; id_inc_s = 1'b1; cnt_s = 16'd0; end
                        default:     cmd_err_s = 1'b0;
                    endcase
                end
            end
            default: cnt_s = 16'd0;
        endcase
        if (drop_s && (ovr_r != {OVR_W{1'b1}})) ovr_s = ovr_r + OVR_W'(1);
        else                                    ovr_s = ovr_r;
    end

    // Registered control state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'd0;  e_d_r <= 1'b0;  ac_r <= 7'd0;  shift_r <= 6'd0;
            disp_on_r <= 1'b0;  cursor_on_r <= 1'b0;  blink_on_r <= 1'b0;
            id_inc_r <= 1'b1;  entry_shift_r <= 1'b0;  two_line_r <= 1'b0;
            wr_strobe_r <= 1'b0;  cmd_err_r <= 1'b0;  busy_r <= 1'b1;
            ovr_r <= {OVR_W{1'b0}};  dbg_data_r <= 8'h00;
        end else begin
            cnt_r <= cnt_s;  e_d_r <= lcd.LCD_E;  ac_r <= ac_s;  shift_r <= shift_s;
            disp_on_r <= disp_on_s;  cursor_on_r <= cursor_on_s;  blink_on_r <= blink_on_s;
            id_inc_r <= id_inc_s;  entry_shift_r <= entry_shift_s;  two_line_r <= two_line_s;
            wr_strobe_r <= wr_strobe_s;  cmd_err_r <= cmd_err_s;
            busy_r <= (state_s != S_IDLE);
            ovr_r <= ovr_s;
            // Read-before-write: a same-cycle write to this index is seen next cycle.
            dbg_data_r <= (dbg_idx_s < 7'd80) ? ram_r[dbg_idx_s] : 8'h00;
        end
    end

    // DDRAM write port (contents survive reset; INIT_FILL rewrites them)
    always_ff @(posedge clk) begin
        if (ram_we_s) ram_r[ram_idx_s] <= ram_wd_s;
    end

    assign dbg_data    = dbg_data_r;
    assign bf_ac       = {busy_r, ac_r};
    assign busy        = busy_r;
    assign disp_on     = disp_on_r;
    assign cursor_on   = cursor_on_r;
    assign blink_on    = blink_on_r;
    assign id_inc      = id_inc_r;
    assign entry_shift = entry_shift_r;
    assign two_line    = two_line_r;
    assign disp_shift  = shift_r;
    assign wr_strobe   = wr_strobe_r;
    assign cmd_err     = cmd_err_r;
    assign ovr_cnt     = ovr_r;
endmodule
